// File: rtl/powlib_sfifo_pkg.sv
// powlib_sfifo_pkg
// Shared definitions for the single-clock FIFO slice:
//   - default width/depth used by the FIFO and its handshake interface
//   - powlib_clogb2: index width needed to address a given number of words
//   - xfer_e: which handshakes fire in a cycle (write, read, both, none)
package powlib_sfifo_pkg;

  localparam int SFIFO_W_DEF = 16;
  localparam int SFIFO_D_DEF = 8;

  // Smallest n with 2**n >= value (0 for value <= 1).
  function automatic int powlib_clogb2(input int value);
    int result;
    result = 0;
    for (int i = 0; i < 31; i++) begin
      if ((32'sd1 <<< i) < value) begin
        result = i + 1;
      end else begin
        result = result;
      end
    end
    return result;
  endfunction

  // Bit 0 = write fires, bit 1 = read fires.
  typedef enum logic [1:0] {
    XFER_NONE = 2'b00,
    XFER_WR   = 2'b01,
    XFER_RD   = 2'b10,
    XFER_BOTH = 2'b11
  } xfer_e;

endpackage

// File: rtl/powlib_sfifo_if.sv
// powlib_sfifo_if
// Handshake and status bundle of powlib_sfifo.
//   W   data width
//   CW  occupancy width (index width + 1)
// Signals:
//   wrdata/wrvld/wrrdy  write side valid/ready
//   rddata/rdvld/rdrdy  read side valid/ready
//   full/empty/afull    status flags
//   count               occupancy 0..D
// Modports:
//   slave   FIFO side (consumes writes, produces reads and status)
//   master  user side (producer and consumer)
interface powlib_sfifo_if
  import powlib_sfifo_pkg::*;
#(
  parameter int W  = SFIFO_W_DEF,
  parameter int CW = powlib_clogb2(SFIFO_D_DEF) + 1
);
  logic [W-1:0]  wrdata;
  logic          wrvld;
  logic          wrrdy;
  logic [W-1:0]  rddata;
  logic          rdvld;
  logic          rdrdy;
  logic          full;
  logic          empty;
  logic          afull;
  logic [CW-1:0] count;

  modport slave (
    input  wrdata, wrvld, rdrdy,
    output wrrdy, rddata, rdvld, full, empty, afull, count
  );

  modport master (
    output wrdata, wrvld, rdrdy,
    input  wrrdy, rddata, rdvld, full, empty, afull, count
  );
endinterface

// File: rtl/powlib_sfifo_dpram.sv
// powlib_dpram
// Simple dual-port RAM: one synchronous write port, one combinational
// read port, no reset of the contents.
// Ports:
//   clk     clock
//   wridx   write address
//   wrdata  write data
//   wrvld   write enable
//   wrbe    byte enables, honoured only when EWBE != 0
//   rdidx   read address
//   rddata  combinational read data
module powlib_dpram
  import powlib_sfifo_pkg::*;
#(
  parameter int W    = SFIFO_W_DEF,
  parameter int D    = SFIFO_D_DEF,
  parameter int WIDX = powlib_clogb2(D),
  parameter int EWBE = 0,
  parameter int BW   = (W + 7) / 8
) (
  input  logic            clk,
  input  logic [WIDX-1:0] wridx,
  input  logic [W-1:0]    wrdata,
  input  logic            wrvld,
  input  logic [BW-1:0]   wrbe,
  input  logic [WIDX-1:0] rdidx,
  output logic [W-1:0]    rddata
);

  logic [W-1:0] mem_r [D];
  logic [W-1:0] bitmask_s;

  // Expand byte enables to a per-bit mask; all bits written when EWBE==0.
  for (genvar gi = 0; gi < W; gi++) begin : g_mask
    assign bitmask_s[gi] = (EWBE == 0) ? 1'b1 : wrbe[gi / 8];
  end

  // Storage write; unmasked bits keep their old value.
  always_ff @(posedge clk) begin
    if (wrvld) begin
      mem_r[wridx] <= (mem_r[wridx] & ~bitmask_s) | (wrdata & bitmask_s);
    end
  end

  assign rddata = mem_r[rdidx];

endmodule

// File: rtl/powlib_sfifo.sv
// powlib_sfifo
// Single-clock FIFO controller running a powlib_dpram as a circular buffer.
// Pointers carry one extra wrap bit so full and empty are distinguishable.
// All status flags are registers loaded from the next-state pointers, so
// there is no combinational path from wrvld/rdrdy to any status output.
// Ports:
//   clk   clock
//   rst   asynchronous active-low reset, release sampled on clk
//   bus   powlib_sfifo_if.slave: write/read handshakes, full, empty,
//         afull (count >= AFT) and count (0..D)
module powlib_sfifo
  import powlib_sfifo_pkg::*;
#(
  parameter int    W    = SFIFO_W_DEF,
  parameter int    D    = SFIFO_D_DEF,
  parameter int    WIDX = powlib_clogb2(D),
  parameter int    AFT  = D - 2,
  parameter int    EDBG = 0,
  parameter string ID   = "SFIFO"
) (
  input  logic           clk,
  input  logic           rst,
  powlib_sfifo_if.slave  bus
);

  localparam int              BW        = (W + 7) / 8;
  localparam logic [WIDX:0]   PTR_ONE   = {{WIDX{1'b0}}, 1'b1};
  localparam logic [WIDX:0]   AFT_C     = (WIDX + 1)'(AFT);
  localparam logic            AFULL_RST = (AFT == 0) ? 1'b1 : 1'b0;

  // Parameter sanity check, only when debugging is enabled.
  if (EDBG != 0) begin : g_dbg
    if ((D < 2) || ((D & (D - 1)) != 0) || (AFT > D)) begin : g_bad
      $fatal(1, "%s: D must be a power of 2 >= 2 and AFT <= D", ID);
    end
  end

  logic [WIDX:0] wrptr_r, rdptr_r, count_r;
  logic          full_r, empty_r, afull_r;

  logic          wr_s, rd_s;
  xfer_e         xfer_s;
  logic [WIDX:0] wrptr_nxt_s, rdptr_nxt_s, count_nxt_s;
  logic          full_nxt_s, empty_nxt_s, afull_nxt_s;
  logic [BW-1:0] wrbe_s;

  assign wrbe_s = {BW{1'b1}};

  // Handshake fire decode and next-state pointers/status.
  always_comb begin
    wr_s        = bus.wrvld & ~full_r;
    rd_s        = bus.rdrdy & ~empty_r;
    xfer_s      = xfer_e'({rd_s, wr_s});
    wrptr_nxt_s = wrptr_r;
    rdptr_nxt_s = rdptr_r;
    case (xfer_s)
      XFER_NONE: begin
        wrptr_nxt_s = wrptr_r;
        rdptr_nxt_s = rdptr_r;
      end
      XFER_WR: begin
        wrptr_nxt_s = wrptr_r + PTR_ONE;
      end
      XFER_RD: begin
        rdptr_nxt_s = rdptr_r + PTR_ONE;
      end
      XFER_BOTH: begin
        wrptr_nxt_s = wrptr_r + PTR_ONE;
        rdptr_nxt_s = rdptr_r + PTR_ONE;
      end
      default: begin
        wrptr_nxt_s = wrptr_r;
        rdptr_nxt_s = rdptr_r;
      end
    endcase
    // Modulo 2^(WIDX+1) difference gives occupancy 0..D directly.
    count_nxt_s = wrptr_nxt_s - rdptr_nxt_s;
    empty_nxt_s = (wrptr_nxt_s == rdptr_nxt_s);
    full_nxt_s  = (wrptr_nxt_s[WIDX-1:0] == rdptr_nxt_s[WIDX-1:0]) &&
                  (wrptr_nxt_s[WIDX] != rdptr_nxt_s[WIDX]);
    afull_nxt_s = (count_nxt_s >= AFT_C);
  end

  // Pointer, occupancy and status registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wrptr_r <= '0;
      rdptr_r <= '0;
      count_r <= '0;
      full_r  <= 1'b0;
      empty_r <= 1'b1;
      afull_r <= AFULL_RST;
    end else begin
      wrptr_r <= wrptr_nxt_s;
      rdptr_r <= rdptr_nxt_s;
      count_r <= count_nxt_s;
      full_r  <= full_nxt_s;
      empty_r <= empty_nxt_s;
      afull_r <= afull_nxt_s;
    end
  end

  powlib_dpram #(
    .W    (W),
    .D    (D),
    .WIDX (WIDX),
    .EWBE (0),
    .BW   (BW)
  ) u_ram (
    .clk    (clk),
    .wridx  (wrptr_r[WIDX-1:0]),
    .wrdata (bus.wrdata),
    .wrvld  (wr_s),
    .wrbe   (wrbe_s),
    .rdidx  (rdptr_r[WIDX-1:0]),
    .rddata (bus.rddata)
  );

  assign bus.wrrdy = ~full_r;
  assign bus.rdvld = ~empty_r;
  assign bus.full  = full_r;
  assign bus.empty = empty_r;
  assign bus.afull = afull_r;
  assign bus.count = count_r;

endmodule

// File: tb/tb_powlib_sfifo.sv
// tb_powlib_sfifo
// Directed bench for powlib_sfifo (W=16, D=8, AFT=6). A queue holds the
// expected FIFO contents; every falling edge the monitor compares all
// outputs against what that queue implies, and the stimulus sequence adds
// hand-computed literal expectations at key points.
module tb_powlib_sfifo;

  localparam int W  = 16;
  localparam int D  = 8;
  localparam int CW = 4;

  logic clk;
  logic rst;
  int   total;
  int   bad;
  bit   mon_on;

  logic [W-1:0] mq[$];

  powlib_sfifo_if #(.W(W), .CW(CW)) bus ();

  powlib_sfifo #(.W(W), .D(D)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h at t=%0t", nm, act, exp, $time);
    end
  endtask

  // One clock: drive inputs after the falling edge, update the model at
  // the rising edge from the pre-edge occupancy, return at the next fall.
  task automatic step(input logic wv, input logic [W-1:0] wd, input logic rr);
    bit wf, rf;
    bus.wrvld  = wv;
    bus.wrdata = wd;
    bus.rdrdy  = rr;
    wf = wv && (mq.size() < D);
    rf = rr && (mq.size() > 0);
    @(posedge clk);
    if (rf) void'(mq.pop_front());
    if (wf) mq.push_back(wd);
    @(negedge clk);
    bus.wrvld  = 1'b0;
    bus.wrdata = '0;
    bus.rdrdy  = 1'b0;
  endtask

  // Per-cycle comparison of every output against the queue model.
  always @(negedge clk) begin
    if (mon_on) begin
      chk("m_count", 32'(bus.count), 32'(mq.size()));
      chk("m_empty", 32'(bus.empty), 32'(mq.size() == 0));
      chk("m_full",  32'(bus.full),  32'(mq.size() == D));
      chk("m_afull", 32'(bus.afull), 32'(mq.size() >= D - 2));
      chk("m_wrrdy", 32'(bus.wrrdy), 32'(mq.size() != D));
      chk("m_rdvld", 32'(bus.rdvld), 32'(mq.size() != 0));
      if (mq.size() > 0) chk("m_rddata", 32'(bus.rddata), 32'(mq[0]));
    end
  end

  initial begin
    total = 0;
    bad = 0;
    mon_on = 1'b0;
    bus.wrvld = 1'b0;
    bus.wrdata = '0;
    bus.rdrdy = 1'b0;
    rst = 1'b1;
    #1 rst = 1'b0;
    mon_on = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("rst_count", 32'(bus.count), 32'd0);
    chk("rst_empty", 32'(bus.empty), 32'd1);
    chk("rst_full",  32'(bus.full),  32'd0);
    chk("rst_afull", 32'(bus.afull), 32'd0);
    chk("rst_wrrdy", 32'(bus.wrrdy), 32'd1);
    chk("rst_rdvld", 32'(bus.rdvld), 32'd0);
    rst = 1'b1;

    // Fill to full.
    for (int i = 1; i <= 8; i++) begin
      step(1'b1, 16'(i), 1'b0);
      chk("fill_count", 32'(bus.count), 32'(i));
      chk("fill_afull", 32'(bus.afull), (i >= 6) ? 32'd1 : 32'd0);
    end
    chk("fill_full",  32'(bus.full),  32'd1);
    chk("fill_wrrdy", 32'(bus.wrrdy), 32'd0);
    step(1'b1, 16'h0009, 1'b0);
    chk("wr_full_ign", 32'(bus.count), 32'd8);

    // Drain in order.
    for (int i = 1; i <= 8; i++) begin
      chk("drain_data", 32'(bus.rddata), 32'(i));
      step(1'b0, 16'h0000, 1'b1);
    end
    chk("drain_empty", 32'(bus.empty), 32'd1);
    chk("drain_count", 32'(bus.count), 32'd0);
    step(1'b0, 16'h0000, 1'b1);
    chk("rd_empty_ign", 32'(bus.count), 32'd0);

    // Full with simultaneous push and pop.
    for (int i = 1; i <= 8; i++) step(1'b1, 16'(i), 1'b0);
    chk("refill_full", 32'(bus.full), 32'd1);
    step(1'b1, 16'h0055, 1'b1);
    chk("fullrw_count", 32'(bus.count), 32'd7);
    chk("fullrw_head",  32'(bus.rddata), 32'h0002);
    step(1'b1, 16'h0055, 1'b0);
    chk("fullrw_next", 32'(bus.count), 32'd8);
    for (int i = 0; i < 7; i++) step(1'b0, 16'h0000, 1'b1);
    chk("fullrw_last", 32'(bus.rddata), 32'h0055);
    step(1'b0, 16'h0000, 1'b1);

    // Empty with simultaneous push and pop.
    step(1'b1, 16'hABCD, 1'b1);
    chk("emptyrw_count", 32'(bus.count), 32'd1);
    chk("emptyrw_rdvld", 32'(bus.rdvld), 32'd1);
    chk("emptyrw_data",  32'(bus.rddata), 32'h0000ABCD);
    step(1'b0, 16'h0000, 1'b1);

    // Streaming: one in, one out every cycle; pointers wrap repeatedly.
    step(1'b1, 16'h1000, 1'b0);
    for (int i = 1; i < 20; i++) begin
      step(1'b1, 16'(16'h1000 + i), 1'b1);
      chk("stream_count", 32'(bus.count), 32'd1);
      chk("stream_data",  32'(bus.rddata), 32'(16'h1000 + i));
    end
    step(1'b0, 16'h0000, 1'b1);

    // Asynchronous reset in the middle of a cycle with 5 words stored.
    for (int i = 0; i < 5; i++) step(1'b1, 16'(16'h2000 + i), 1'b0);
    chk("pre_rst_count", 32'(bus.count), 32'd5);
    #2;
    rst = 1'b0;
    mq.delete();
    #1;
    chk("arst_count", 32'(bus.count), 32'd0);
    chk("arst_empty", 32'(bus.empty), 32'd1);
    chk("arst_rdvld", 32'(bus.rdvld), 32'd0);
    chk("arst_wrrdy", 32'(bus.wrrdy), 32'd1);
    chk("arst_afull", 32'(bus.afull), 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    step(1'b1, 16'h3333, 1'b0);
    chk("post_rst_count", 32'(bus.count), 32'd1);
    chk("post_rst_data",  32'(bus.rddata), 32'h00003333);
    step(1'b0, 16'h0000, 1'b1);
    chk("post_rst_empty", 32'(bus.empty), 32'd1);

    mon_on = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
